// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit
// Purpose : RV32I branch condition evaluation behind a valid/ready stage,
//           misprediction resolution and a 2-bit saturating BHT with a
//           registered lookup port. Optional macro: BRANCH_RESOLVE_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int PC_LSB    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [1:0]      out_passcond,
    output logic            out_mispredict,
    input  logic [XLEN-1:0] lookup_pc,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            lookup_taken
);

    localparam int c_IDX_W = $clog2(BHT_DEPTH);

    // ------------------------------------------------------------------
    // Flags and condition
    // ------------------------------------------------------------------
    logic [XLEN:0] w_diff;
    logic          w_n, w_z, w_c, w_v, w_ge;
    logic          w_cond, w_cond_ok, w_pass, w_taken, w_accept;

    assign w_diff = {1'b0, rs1} - {1'b0, rs2};
    assign w_n    = w_diff[XLEN-1];
    assign w_z    = (rs1 == rs2);
    assign w_c    = ~w_diff[XLEN];
    assign w_v    = (rs1[XLEN-1] != rs2[XLEN-1]) & (w_diff[XLEN-1] != rs1[XLEN-1]);
    assign w_ge   = (w_n == w_v);

    always_comb begin
        w_cond    = 1'b1;
        w_cond_ok = 1'b1;
        case (funct3)
            3'b000:  w_cond = w_z;
            3'b001:  w_cond = ~w_z;
            3'b100:  w_cond = ~w_ge;
            3'b101:  w_cond = w_ge;
            3'b110:  w_cond = ~w_c;
            3'b111:  w_cond = w_c;
            // 010/011 pass for legacy compatibility but never count as taken
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_pass   = ~branch | w_cond;
    assign w_taken  = branch & w_cond_ok & w_cond;
    assign in_ready = ~out_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    logic       r_valid, r_taken, r_pass, r_mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_pass       <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_taken      <= w_taken;
            r_pass       <= w_pass;
            r_mispredict <= w_taken ^ pred_taken;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_taken      = r_taken;
    assign out_passcond   = {2{r_pass}};
    assign out_mispredict = r_mispredict;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]         r_bht [BHT_DEPTH];
    logic               r_lookup_taken;
    logic [c_IDX_W-1:0] w_upd_idx, w_lk_idx;
    logic [1:0]         w_cur, w_next;
    logic               w_bht_upd;

    assign w_upd_idx = pc[PC_LSB +: c_IDX_W];
    assign w_lk_idx  = lookup_pc[PC_LSB +: c_IDX_W];
    assign w_cur     = r_bht[w_upd_idx];
    assign w_bht_upd = w_accept & branch & w_cond_ok;

    always_comb begin
        w_next = w_cur;
        if (w_taken) begin
            if (w_cur != 2'b11) w_next = w_cur + 2'b01;
        end else begin
            if (w_cur != 2'b00) w_next = w_cur - 2'b01;
        end
    end

    // Lookup samples the array before this edge's update lands (read-before-write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
            r_lookup_taken <= 1'b0;
        end else begin
            r_lookup_taken <= r_bht[w_lk_idx][1];
            if (w_bht_upd) r_bht[w_upd_idx] <= w_next;
        end
    end

    assign lookup_taken = r_lookup_taken;

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = &{1'b0, pc, lookup_pc};

`ifdef BRANCH_RESOLVE_STATS_EN
    // ------------------------------------------------------------------
    // Transfer statistics; a flushed transfer is not counted
    // ------------------------------------------------------------------
    logic        r_branch;
    logic [31:0] r_stat_br, r_stat_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch   <= 1'b0;
            r_stat_br  <= 32'd0;
            r_stat_mis <= 32'd0;
        end else begin
            if (w_accept) r_branch <= branch;
            if (r_valid & out_ready & ~flush) begin
                if (r_branch)     r_stat_br  <= r_stat_br + 32'd1;
                if (r_mispredict) r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_unit
// Purpose : Vector table, directed corner sequences and randomized traffic
//           checked against a behavioural model of branch_resolve_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, branch, pred_taken;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, lookup_pc;
    logic        out_valid, out_ready, out_taken, out_mispredict, lookup_taken;
    logic [1:0]  out_passcond;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .PC_LSB(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .branch(branch), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .pc(pc), .pred_taken(pred_taken), .out_valid(out_valid),
        .out_ready(out_ready), .out_taken(out_taken), .out_passcond(out_passcond),
        .out_mispredict(out_mispredict), .lookup_pc(lookup_pc),
`ifdef BRANCH_RESOLVE_STATS_EN
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
        .lookup_taken(lookup_taken)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: branch semantics from plain comparisons
    // ------------------------------------------------------------------
    function automatic logic cond_pass(input logic br, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        if (!br) return 1'b1;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic is_real_branch(input logic br, input logic [2:0] f3);
        return br && f3 != 3'd2 && f3 != 3'd3;
    endfunction

    int          m_bht [16];
    logic        m_valid, m_taken, m_pass, m_mis, m_branch, m_lookup;
    logic [31:0] m_stat_br, m_stat_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
            m_valid <= 0; m_taken <= 0; m_pass <= 0; m_mis <= 0; m_branch <= 0;
            m_lookup <= 0; m_stat_br <= 0; m_stat_mis <= 0;
        end else begin
            m_lookup <= (m_bht[(lookup_pc >> 2) % 16] >= 2);
            if (!flush && m_valid && out_ready) begin
                if (m_branch) m_stat_br  <= m_stat_br + 1;
                if (m_mis)    m_stat_mis <= m_stat_mis + 1;
            end
            if (flush) begin
                m_valid <= 0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                logic t;
                int   k;
                t = is_real_branch(branch, funct3) && cond_pass(branch, funct3, rs1, rs2);
                m_valid  <= 1;
                m_taken  <= t;
                m_pass   <= cond_pass(branch, funct3, rs1, rs2);
                m_mis    <= (t != pred_taken);
                m_branch <= branch;
                if (is_real_branch(branch, funct3)) begin
                    k = (pc >> 2) % 16;
                    if (t) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
                    else   m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
                end
            end else if (out_ready) begin
                m_valid <= 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        br;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        pred;
        logic        e_taken;
        logic [1:0]  e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vt [12];

    task automatic send(input logic br, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic pred, input logic [31:0] p);
        in_valid = 1; branch = br; funct3 = f3; rs1 = a; rs2 = b; pred_taken = pred; pc = p;
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; branch = 0; funct3 = 0; rs1 = 0; rs2 = 0;
        pc = 0; pred_taken = 0; out_ready = 1; lookup_pc = 0;

        vt[0]  = '{1, 3'd0, 32'd5,        32'd5,        0, 1, 2'b11, 1};
        vt[1]  = '{1, 3'd4, 32'hFFFFFFFF, 32'd1,        1, 1, 2'b11, 0};
        vt[2]  = '{1, 3'd6, 32'hFFFFFFFF, 32'd1,        1, 0, 2'b00, 1};
        vt[3]  = '{1, 3'd5, 32'h80000000, 32'h7FFFFFFF, 0, 0, 2'b00, 0};
        vt[4]  = '{1, 3'd1, 32'd3,        32'd4,        1, 1, 2'b11, 0};
        vt[5]  = '{1, 3'd7, 32'd1,        32'hFFFFFFFF, 0, 0, 2'b00, 0};
        vt[6]  = '{1, 3'd2, 32'd7,        32'd9,        1, 0, 2'b11, 1};
        vt[7]  = '{0, 3'd0, 32'd1,        32'd2,        1, 0, 2'b11, 1};
        vt[8]  = '{1, 3'd4, 32'h80000000, 32'h7FFFFFFF, 0, 1, 2'b11, 1};
        vt[9]  = '{1, 3'd5, 32'h7FFFFFFF, 32'h80000000, 1, 1, 2'b11, 0};
        vt[10] = '{1, 3'd0, 32'd0,        32'd1,        0, 0, 2'b00, 0};
        vt[11] = '{1, 3'd3, 32'd0,        32'd0,        0, 0, 2'b11, 0};

        @(negedge clk); @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_passcond", out_passcond, 0);
        chk("rst_mispredict", out_mispredict, 0);
        chk("rst_lookup", lookup_taken, 0);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            send(vt[i].br, vt[i].f3, vt[i].a, vt[i].b, vt[i].pred, 32'h100 + i * 4);
            tick();
            in_valid = 0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_taken", i), out_taken, vt[i].e_taken);
            chk($sformatf("vec%0d_passcond", i), out_passcond, vt[i].e_pc);
            chk($sformatf("vec%0d_mispredict", i), out_mispredict, vt[i].e_mis);
        end
        tick();
        chk("idle_valid", out_valid, 0);

        // Backpressure: second request waits while the first is held
        out_ready = 0;
        send(1, 3'd0, 32'd5, 32'd5, 0, 32'h300);
        tick();
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_taken", out_taken, 1);
        send(1, 3'd1, 32'd5, 32'd5, 0, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_taken", out_taken, 1);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_taken", out_taken, 0);
        chk("bp_second_passcond", out_passcond, 2'b00);
        tick();
        chk("bp_drained", out_valid, 0);

        // Reset in the middle of a held transfer
        out_ready = 0;
        send(1, 3'd0, 32'd1, 32'd1, 0, 32'h40);
        tick();
        in_valid = 0;
        chk("mid_held", out_valid, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        tick();
        rst_n = 1;
        out_ready = 1;
        lookup_pc = 32'h40;
        tick();
        chk("bht_init", lookup_taken, 0);

        // BHT training at pc 0x40 with read-before-write lookups
        send(1, 3'd0, 32'd2, 32'd2, 0, 32'h40);           // 01 -> 10
        tick(); in_valid = 0;
        chk("bht_rbw_old01", lookup_taken, 0);
        tick();
        chk("bht_now10", lookup_taken, 1);
        for (int i = 0; i < 2; i++) begin                 // 10 -> 11 -> 11
            send(1, 3'd0, 32'd2, 32'd2, 1, 32'h40);
            tick(); in_valid = 0;
            tick();
            chk("bht_sat11", lookup_taken, 1);
        end
        send(1, 3'd0, 32'd2, 32'd3, 1, 32'h40);           // 11 -> 10
        tick(); in_valid = 0;
        chk("bht_rbw_old11", lookup_taken, 1);
        tick();
        chk("bht_now10b", lookup_taken, 1);
        send(1, 3'd0, 32'd2, 32'd3, 1, 32'h40);           // 10 -> 01
        tick(); in_valid = 0;
        chk("bht_rbw_old10", lookup_taken, 1);
        tick();
        chk("bht_now01", lookup_taken, 0);

        // Flush while both a result and a new request are present
        out_ready = 0;
        send(0, 3'd0, 32'd0, 32'd0, 1, 32'h200);
        tick();
        chk("fl_pre_valid", out_valid, 1);
        send(1, 3'd0, 32'd5, 32'd5, 0, 32'h40);
        out_ready = 1;
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("fl_valid", out_valid, 0);
        tick();
        chk("fl_bht_unchanged", lookup_taken, 0);
        chk("fl_still_idle", out_valid, 0);
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("fl_stat_br", stat_branches, m_stat_br);
        chk("fl_stat_mis", stat_mispredicts, m_stat_mis);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            branch     = ($urandom_range(0, 7) != 0);
            funct3     = 3'($urandom_range(0, 7));
            a          = $urandom;
            rs1        = ($urandom_range(0, 1) != 0) ? a : 32'($urandom_range(0, 3));
            rs2        = ($urandom_range(0, 3) == 0) ? rs1 :
                         (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)));
            pred_taken = 1'($urandom_range(0, 1));
            pc         = 32'($urandom_range(0, 7)) << 2;
            lookup_pc  = 32'($urandom_range(0, 7)) << 2;
            #1;
            chk("rnd_in_ready", in_ready, !m_valid || out_ready);
            tick();
            chk("rnd_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_taken", out_taken, m_taken);
                chk("rnd_passcond", out_passcond, {2{m_pass}});
                chk("rnd_mispredict", out_mispredict, m_mis);
            end
            chk("rnd_lookup", lookup_taken, m_lookup);
`ifdef BRANCH_RESOLVE_STATS_EN
            chk("rnd_stat_br", stat_branches, m_stat_br);
            chk("rnd_stat_mis", stat_mispredicts, m_stat_mis);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor of the combinational branch-condition block; next generation for the pipelined core.
- Generates N/Z/C/V internally from XLEN-wide operands and evaluates all RV32I branch funct3 conditions.
- Registers the result behind a valid/ready stage and resolves against fetch's prediction.
- Owns a 2-bit saturating branch history table (BHT) with a registered lookup port for fetch.

Parameters:
XLEN, 32, operand and PC width.
BHT_DEPTH, 16, BHT entries; power of 2, minimum 2.
PC_LSB, 2, lowest PC bit used for BHT index; index = pc[PC_LSB +: log2(BHT_DEPTH)].

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  kill the pipeline register contents.
in_valid  in  1  resolve request valid.
in_ready  out  1  stage can accept a request.
branch  in  1  instruction is a conditional branch.
funct3  in  3  branch condition code.
rs1  in  XLEN  operand A.
rs2  in  XLEN  operand B.
pc  in  XLEN  branch PC; used for BHT update index.
pred_taken  in  1  direction fetch predicted.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_taken  out  1  branch resolved taken.
out_passcond  out  2  2'b11 on pass, else 2'b00; legacy encoding.
out_mispredict  out  1  out_taken != registered pred_taken.
lookup_pc  in  XLEN  fetch lookup address.
lookup_taken  out  1  registered prediction; MSB of the indexed counter.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_taken=0, out_passcond=2'b00, out_mispredict=0, lookup_taken=0.
  - All BHT counters set to 2'b01 (weakly not-taken).
- Flags, combinational from inputs:
  - diff = {1'b0,rs1} - {1'b0,rs2}, XLEN+1 bits.
  - N = diff[XLEN-1]; Z = (rs1==rs2); C = ~diff[XLEN] (no borrow, i.e. rs1>=rs2 unsigned).
  - V = (rs1[XLEN-1]!=rs2[XLEN-1]) & (diff[XLEN-1]!=rs1[XLEN-1]); ge = (N==V).
- Condition (pass):
  - 000 → Z; 001 → ~Z; 100 → ~ge; 101 → ge; 110 → ~C; 111 → C.
  - 010 and 011 → pass=1 (legacy default).
  - branch=0 → pass=1.
- taken = branch & pass & funct3 is one of {000,001,100,101,110,111}.
- passcond = pass ? 2'b11 : 2'b00.
- Handshake:
  - in_ready = ~out_valid | out_ready; combinational, no dependence on in_valid.
  - Accept when in_valid & in_ready; result appears registered the next cycle. Latency 1.
  - Output holds stable while out_valid & ~out_ready.
  - out_valid clears after the transfer unless a new request is accepted the same cycle.
- Flush:
  - The cycle after flush=1, out_valid=0.
  - A request offered during flush is dropped: not registered, no BHT update.
  - Flush has priority over every other event.
- BHT update:
  - On accept of a valid branch (branch=1, valid funct3), not flushed.
  - Indexed counter increments toward 2'b11 if taken, decrements toward 2'b00 if not.
  - Saturates at both ends, no wrap.
- Lookup:
  - lookup_taken is registered every cycle from lookup_pc's index; 1-cycle latency.
  - Update and lookup to the same index in the same cycle: lookup returns the pre-update value (read-before-write).
- Non-branch requests still produce a result; out_mispredict = pred_taken.
- rst_n asserted mid-transfer: result discarded, BHT reinitialised, in_ready=1 once reset releases.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Counters increment on each output transfer (out_valid & out_ready) with branch=1 and mispredict=1 respectively.
  - Both cleared by reset; wrap at 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then BEQ rs1=5, rs2=5, pred_taken=0, out_ready=1 → next cycle out_valid=1, out_taken=1, out_passcond=11, out_mispredict=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken=1; BLTU with the same operands → taken=0, passcond=00.
- BGE rs1=0x80000000, rs2=0x7FFFFFFF (overflow case) → taken=0.
- Backpressure: out_ready=0 for 3 cycles with a second request pending → in_ready=0, output stable; out_ready=1 → second result the next cycle, no loss or duplication.
- BHT: 3 taken branches at pc=0x40, then lookup_pc=0x40 → counter 01→10→11→11, lookup_taken=1.
  - Same-cycle update plus lookup at the index → old value returned.
- Flush with in_valid=1 and out_valid=1 → out_valid=0 next cycle, BHT entry unchanged; with BRANCH_RESOLVE_STATS_EN, counters unchanged.
